// File: rtl/controlador_varredura_display_pkg.sv
// Shared types, width helpers and the leading-zero blank-mask function
// for the display scan controller.
package controlador_varredura_display_pkg;

    // Scan FSM: ON lights the current digit, GAP turns every digit off.
    typedef enum logic {
        ST_ON  = 1'b0,
        ST_GAP = 1'b1
    } state_t;

    // Widest digit count the blank-mask function handles.
    localparam int MAX_DIG = 8;

    // Default geometry of the adder display board.
    localparam int DEF_NUM_DIG = 4;
    localparam int DEF_DIV     = 50000;
    localparam int IDX_W_DEF   = $clog2(DEF_NUM_DIG);
    localparam int CNT_W_DEF   = $clog2(DEF_DIV);

    // Digit-index width; never below one bit.
    function automatic int idx_width(input int num_dig);
        return (num_dig < 2) ? 1 : $clog2(num_dig);
    endfunction

    // Slot-counter width; never below one bit.
    function automatic int cnt_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

    // Digit i (i != 0) is blanked when suppression is on and digits
    // i..num_dig-1 are all zero. Digit 0 is never blanked.
    function automatic logic [MAX_DIG-1:0] blank_mask(
        input logic [4*MAX_DIG-1:0] disp,
        input logic                 lzs,
        input int                   num_dig
    );
        logic [MAX_DIG-1:0] mask;
        logic               zero_above;
        mask       = '0;
        zero_above = 1'b1;
        for (int i = MAX_DIG - 1; i >= 1; i--) begin
            if (i < num_dig) begin
                zero_above = zero_above & (disp[4*i +: 4] == 4'd0);
                mask[i]    = lzs & zero_above;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/controlador_varredura_display_divisor.sv
// Slot counter: runs 0..DIV-1 once per digit slot and flags the last ON
// cycle (gap_start) and the last cycle of the slot (slot_end).
module divisor_varredura
    import controlador_varredura_display_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 2,
    parameter int CNT_W = cnt_width(DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cnt,
    output logic             gap_start,
    output logic             slot_end
);

    // Strobes are plain decodes of the counter value.
    assign gap_start = (cnt == CNT_W'(DIV - BLANK - 1));
    assign slot_end  = (cnt == CNT_W'(DIV - 1));

    // Free-running slot counter, wraps at the end of every slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/controlador_varredura_display.sv
// Time-multiplexed scan controller for NUM_DIG digits sharing one
// 7-segment decoder. Holds a frame-stable display copy loaded through a
// ready/ack handshake that commits only at frame boundaries.
module controlador_varredura_display
    import controlador_varredura_display_pkg::*;
#(
    parameter int NUM_DIG = 4,
    parameter int DIV     = 50000,
    parameter int BLANK   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [4*NUM_DIG-1:0] din,
    output logic                 ready,
    output logic                 ack,
    input  logic                 lzs,
    output logic [3:0]           nib,
    output logic [NUM_DIG-1:0]   an,
    output logic                 frame_start
);

    localparam int IDX_W = idx_width(NUM_DIG);
    localparam int CNT_W = cnt_width(DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIG - 1);

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_next;
    logic [CNT_W-1:0]     cnt;
    logic                 gap_start;
    logic                 slot_end;

    logic [4*NUM_DIG-1:0] display;
    logic [4*NUM_DIG-1:0] stage;
    logic                 pending;
    logic                 boundary;
    logic                 accept;
    logic                 commit;

    logic [4*MAX_DIG-1:0] disp_ext;
    logic [MAX_DIG-1:0]   blank;
    logic [NUM_DIG-1:0]   an_next;
    logic [3:0]           nib_next;
    logic                 fs_next;

    divisor_varredura #(
        .DIV   (DIV),
        .BLANK (BLANK),
        .CNT_W (CNT_W)
    ) u_divisor (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt       (cnt),
        .gap_start (gap_start),
        .slot_end  (slot_end)
    );

    // Frame boundary: last GAP cycle of the most significant digit.
    assign boundary = (state == ST_GAP) && slot_end && (idx == LAST_IDX);
    // Staging is only open while nothing is waiting, so accept and commit
    // are mutually exclusive.
    assign accept   = load && !pending;
    assign commit   = boundary && pending;
    assign ready    = !pending;

    // Scan FSM state and digit index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ON;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Next state: ON until the last ON cycle, GAP until slot end, then
    // advance to the next digit.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            ST_ON: begin
                if (gap_start) state_next = ST_GAP;
            end
            ST_GAP: begin
                if (slot_end) begin
                    state_next = ST_ON;
                    idx_next   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
            end
            default: state_next = ST_ON;
        endcase
    end

    // Load handshake: capture into stage, commit to display at a boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage   <= '0;
            display <= '0;
            pending <= 1'b0;
        end else begin
            if (accept) begin
                stage   <= din;
                pending <= 1'b1;
            end
            if (commit) begin
                display <= stage;
                pending <= 1'b0;
            end
        end
    end

    // Zero-extend the display so the shared mask function can be used.
    always_comb begin
        disp_ext                = '0;
        disp_ext[4*NUM_DIG-1:0] = display;
    end

    assign blank = blank_mask(disp_ext, lzs, NUM_DIG);

    // Pin values derived from the current scan state.
    always_comb begin
        an_next  = '1;
        nib_next = 4'd0;
        fs_next  = 1'b0;
        if (state == ST_ON) begin
            if (!blank[idx]) begin
                an_next[idx] = 1'b0;
                nib_next     = display[4*idx +: 4];
            end
            fs_next = (idx == '0) && (cnt == '0);
        end
    end

    // Output registers: one cycle from scan state to pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= '1;
            nib         <= 4'd0;
            frame_start <= 1'b0;
            ack         <= 1'b0;
        end else begin
            an          <= an_next;
            nib         <= nib_next;
            frame_start <= fs_next;
            ack         <= commit;
        end
    end

endmodule

// File: tb/tb_controlador_varredura_display.sv
// Self-checking bench for controlador_varredura_display (4 digits, DIV=8,
// BLANK=2): time-based reference model, frame-level vector table and
// hand-written corner sequences.
module tb_controlador_varredura_display;

    localparam int NUM_DIG = 4;
    localparam int DIV     = 8;
    localparam int BLANK   = 2;
    localparam int FRAME   = NUM_DIG * DIV;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        load  = 1'b0;
    logic [15:0] din   = 16'h0;
    logic        lzs   = 1'b0;
    logic        ready;
    logic        ack;
    logic [3:0]  nib;
    logic [3:0]  an;
    logic        frame_start;

    controlador_varredura_display #(
        .NUM_DIG (NUM_DIG),
        .DIV     (DIV),
        .BLANK   (BLANK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .din         (din),
        .ready       (ready),
        .ack         (ack),
        .lzs         (lzs),
        .nib         (nib),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: time since reset release plus the registers the
    // handshake rules describe.
    int          t;
    int          s_t;
    int          last_ack_t;
    logic [15:0] m_disp;
    logic [15:0] m_stage;
    bit          m_pend;

    typedef struct packed {
        logic [15:0] din;
        logic        lzs;
        logic [15:0] an_exp;   // an during ON of slot s in [4s+:4]
        logic [15:0] nib_exp;  // nib during ON of slot s in [4s+:4]
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %h want %h", name, t, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_an", 16'(an), 16'hF);
        check("rst_nib", 16'(nib), 16'h0);
        check("rst_fs", 16'(frame_start), 16'h0);
        check("rst_ack", 16'(ack), 16'h0);
        check("rst_ready", 16'(ready), 16'h1);
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        t          = 0;
        m_disp     = 16'h0;
        m_stage    = 16'h0;
        m_pend     = 1'b0;
        last_ack_t = -1;
    endtask

    // One clock: predict outputs for state time t, advance, compare.
    task automatic tick();
        logic [3:0] e_an;
        logic [3:0] e_nib;
        logic       e_fs;
        logic       e_ack;
        logic       e_rdy;
        int         slot;
        int         ph;
        bit         blk;
        slot  = (t / DIV) % NUM_DIG;
        ph    = t % DIV;
        e_an  = 4'hF;
        e_nib = 4'h0;
        blk   = 1'b0;
        if (lzs && slot != 0) begin
            blk = 1'b1;
            for (int j = slot; j < NUM_DIG; j++)
                if (m_disp[4*j +: 4] != 4'h0) blk = 1'b0;
        end
        if (ph < DIV - BLANK && !blk) begin
            e_an[slot] = 1'b0;
            e_nib      = m_disp[4*slot +: 4];
        end
        e_fs  = (t % FRAME) == 0;
        e_ack = ((t % FRAME) == FRAME - 1) && m_pend;
        if (e_ack) begin
            m_disp = m_stage;
            m_pend = 1'b0;
        end else if (load && !m_pend) begin
            m_stage = din;
            m_pend  = 1'b1;
        end
        e_rdy = !m_pend;
        @(posedge clk);
        #1;
        check("an", 16'(an), 16'(e_an));
        check("nib", 16'(nib), 16'(e_nib));
        check("frame_start", 16'(frame_start), 16'(e_fs));
        check("ack", 16'(ack), 16'(e_ack));
        check("ready", 16'(ready), 16'(e_rdy));
        if (ack === 1'b1) last_ack_t = t;
        s_t  = t;
        t++;
        load = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout t=%0d", t);
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        int bt;
        int ack_cnt;

        vecs[0] = '{din: 16'h4321, lzs: 1'b0, an_exp: 16'h7BDE, nib_exp: 16'h4321};
        vecs[1] = '{din: 16'h0050, lzs: 1'b1, an_exp: 16'hFFDE, nib_exp: 16'h0050};
        vecs[2] = '{din: 16'h0050, lzs: 1'b0, an_exp: 16'h7BDE, nib_exp: 16'h0050};
        vecs[3] = '{din: 16'h0000, lzs: 1'b1, an_exp: 16'hFFFE, nib_exp: 16'h0000};
        vecs[4] = '{din: 16'h0A07, lzs: 1'b1, an_exp: 16'hFBDE, nib_exp: 16'h0A07};
        vecs[5] = '{din: 16'h8000, lzs: 1'b1, an_exp: 16'h7BDE, nib_exp: 16'h8000};

        #3;
        // Reset and free-run with no load.
        do_reset();
        tick();
        check("first_an", 16'(an), 16'hE);
        check("first_fs", 16'(frame_start), 16'h1);
        while (t < 2 * FRAME) tick();

        // Load 4321 at cycle 5, ignored 9999 while pending.
        do_reset();
        while (t < 5) tick();
        load = 1'b1; din = 16'h4321;
        tick();
        check("ready_drop", 16'(ready), 16'h0);
        while (t < 10) tick();
        load = 1'b1; din = 16'h9999;
        tick();
        while (t < 2 * FRAME) tick();
        check("ack_time", 16'(last_ack_t), 16'd31);
        while (t < 3 * FRAME) begin
            tick();
            if (s_t % DIV == 3)
                check("nib_4321", 16'(nib), 16'((s_t / DIV) % NUM_DIG + 1));
        end

        // Frame-level vector table.
        for (int v = 0; v < 6; v++) begin
            lzs   = vecs[v].lzs;
            guard = 0;
            while (ready !== 1'b1 && guard < 100) begin tick(); guard++; end
            if (guard >= 100) check("ready_wait", 16'(ready), 16'h1);
            load = 1'b1; din = vecs[v].din;
            tick();
            guard = 0;
            while (ack !== 1'b1 && guard < 2 * FRAME) begin tick(); guard++; end
            if (guard >= 2 * FRAME) check("ack_wait", 16'(ack), 16'h1);
            for (int k = 0; k < FRAME; k++) begin
                tick();
                if (s_t % DIV == 3) begin
                    check("vec_an", 16'(an), 16'(vecs[v].an_exp[4*((s_t/DIV)%NUM_DIG) +: 4]));
                    check("vec_nib", 16'(nib), 16'(vecs[v].nib_exp[4*((s_t/DIV)%NUM_DIG) +: 4]));
                end
            end
        end
        lzs = 1'b0;

        // Load asserted in the exact frame-boundary cycle.
        guard = 0;
        while (!((t % FRAME) == FRAME - 1 && ready === 1'b1) && guard < 100) begin
            tick(); guard++;
        end
        if (guard >= 100) check("bnd_wait", 16'(guard), 16'h0);
        bt   = t;
        load = 1'b1; din = 16'h1234;
        tick();
        check("bnd_no_ack", 16'(ack), 16'h0);
        check("bnd_ready", 16'(ready), 16'h0);
        while (t < bt + FRAME + 2) tick();
        check("bnd_ack_time", 16'(last_ack_t - bt), 16'(FRAME));

        // Randomized traffic against the model.
        for (int r = 0; r < 400; r++) begin
            lzs  = ($urandom_range(0, 7) != 0) ? lzs : ~lzs;
            load = ($urandom_range(0, 3) == 0);
            din  = ($urandom_range(0, 2) == 0) ? 16'($urandom & 32'h00FF) : 16'($urandom);
            tick();
        end
        lzs = 1'b0;

        // Reset mid-GAP of digit 2 with a load pending.
        guard = 0;
        while (!((t % FRAME) == 0 && ready === 1'b1) && guard < 100) begin
            tick(); guard++;
        end
        load = 1'b1; din = 16'hABCD;
        tick();
        while ((t % FRAME) != 2 * DIV + DIV - BLANK) tick();
        do_reset();
        ack_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (ack === 1'b1) ack_cnt++;
        end
        check("rst_no_ack", 16'(ack_cnt), 16'h0);
        check("rst_ready_after", 16'(ready), 16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
